// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  localparam int   UART_WORD_LENGTH = 8;
  localparam logic TX_BUSY_LVL      = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Requester-side and UART-side signals of the transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD_LENGTH = UART_WORD_LENGTH
) ();

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             done;
  logic [NUM_REQ-1:0]             err;
  logic [IDX_W-1:0]               owner;
  logic                           arb_busy;
  logic                           uart_tx_rqst;
  logic [WORD_LENGTH-1:0]         uart_tx_data;
  logic                           uart_ready_busy;

  modport slave (
    input  req, req_data, uart_ready_busy,
    output ack, done, err, owner, arb_busy, uart_tx_rqst, uart_tx_data
  );

  modport master (
    output req, req_data, uart_ready_busy,
    input  ack, done, err, owner, arb_busy, uart_tx_rqst, uart_tx_data
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_picker
// Purpose  : Combinational round-robin pick: first set request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;

  // Rotating the doubled vector puts requester ptr at bit 0.
  assign w_rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IDX_W'(k);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
      w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
    end
  end

  assign idx   = w_sum[IDX_W-1:0];
  assign grant = (|req) ? ({{(NUM_REQ - 1){1'b0}}, 1'b1} << idx) : '0;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter among NUM_REQ clients.
//            Optional LAUNCH watchdog enabled by macro UART_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WORD_LENGTH    = UART_WORD_LENGTH,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int c_idx_w = idx_width(NUM_REQ);

  arb_state_t               r_state, w_state_nxt;
  logic [c_idx_w-1:0]       r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0]       r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]       r_done, w_done_nxt;
  logic [c_idx_w-1:0]       r_owner, w_owner_nxt;
  logic                     r_arb_busy, w_arb_busy_nxt;
  logic                     r_rqst, w_rqst_nxt;
  logic [WORD_LENGTH-1:0]   r_data, w_data_nxt;

  logic [NUM_REQ-1:0]       w_grant;
  logic [c_idx_w-1:0]       w_win;
  logic [WORD_LENGTH-1:0]   w_sel_data;
  logic [NUM_REQ-1:0]       w_owner_oh;
  logic                     w_any;
  logic                     w_uart_busy;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_win)
  );

  assign w_any       = |bus.req;
  assign w_uart_busy = (bus.uart_ready_busy == TX_BUSY_LVL);
  assign w_owner_oh  = {{(NUM_REQ - 1){1'b0}}, 1'b1} << r_owner;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == c_idx_w'(i)) begin
        w_sel_data = bus.req_data[i*WORD_LENGTH +: WORD_LENGTH];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;

  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic [NUM_REQ-1:0] r_err, w_err_nxt;
  logic               w_tmo;

  // Counter is zero on every LAUNCH entry because it clears outside LAUNCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo = (r_state == LAUNCH) && (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_owner    <= '0;
      r_arb_busy <= 1'b0;
      r_rqst     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_ack      <= w_ack_nxt;
      r_done     <= w_done_nxt;
      r_owner    <= w_owner_nxt;
      r_arb_busy <= w_arb_busy_nxt;
      r_rqst     <= w_rqst_nxt;
      r_data     <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (w_uart_busy) begin
          w_state_nxt = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (w_tmo) begin
          w_state_nxt = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!w_uart_busy) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt      = r_ptr;
    w_ack_nxt      = '0;
    w_done_nxt     = '0;
    w_owner_nxt    = r_owner;
    w_arb_busy_nxt = r_arb_busy;
    w_rqst_nxt     = r_rqst;
    w_data_nxt     = r_data;
`ifdef UART_ARB_TIMEOUT_EN
    w_err_nxt      = '0;
`endif
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_data_nxt     = w_sel_data;
          w_owner_nxt    = w_win;
          w_ack_nxt      = w_grant;
          w_arb_busy_nxt = 1'b1;
          w_rqst_nxt     = 1'b1;
          w_ptr_nxt      = (w_win == c_idx_w'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
      end
      LAUNCH: begin
        // Dropping rqst in the start bit keeps the UART from chaining a frame.
        if (w_uart_busy) begin
          w_rqst_nxt = 1'b0;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (w_tmo) begin
          w_rqst_nxt     = 1'b0;
          w_err_nxt      = w_owner_oh;
          w_arb_busy_nxt = 1'b0;
        end
`endif
      end
      WAIT_DONE: begin
        if (!w_uart_busy) begin
          w_done_nxt     = w_owner_oh;
          w_arb_busy_nxt = 1'b0;
        end
      end
      default: begin
        w_arb_busy_nxt = 1'b0;
        w_rqst_nxt     = 1'b0;
      end
    endcase
  end

  assign bus.ack          = r_ack;
  assign bus.done         = r_done;
  assign bus.owner        = r_owner;
  assign bus.arb_busy     = r_arb_busy;
  assign bus.uart_tx_rqst = r_rqst;
  assign bus.uart_tx_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter with a UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int WL    = 8;
  localparam int TMO   = 16;
  localparam int FRAME = 10;
  localparam int LIM   = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_en;

  logic m_bsy;
  int   m_cnt;
  int   m_frames;

  int ack_cnt  [NREQ];
  int done_cnt [NREQ];

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ), .WORD_LENGTH(WL)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .WORD_LENGTH    (WL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // UART model: busy one cycle after rqst, busy for FRAME cycles, then idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bsy    <= 1'b0;
      m_cnt    <= 0;
      m_frames <= 0;
    end else if (m_bsy) begin
      if (m_cnt == FRAME - 1) m_bsy <= 1'b0;
      m_cnt <= m_cnt + 1;
    end else if (model_en && bus.uart_tx_rqst) begin
      m_bsy    <= 1'b1;
      m_cnt    <= 0;
      m_frames <= m_frames + 1;
    end
  end

  assign bus.uart_ready_busy = m_bsy;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i])  ack_cnt[i]  = ack_cnt[i] + 1;
      if (bus.done[i]) done_cnt[i] = done_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel: 0 = ack, 1 = done, 2 = err
  task automatic wait_vec(input int sel, input string tag,
                          output logic [NREQ-1:0] v, output int cyc);
    v   = '0;
    cyc = 0;
    while (v == '0 && cyc < LIM) begin
      @(negedge clk);
      cyc++;
      v = (sel == 0) ? bus.ack : (sel == 1) ? bus.done : bus.err;
    end
    check({tag, "_seen"}, 32'(v != '0), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin : stim
    logic [NREQ-1:0] v;
    int              c;
    int              snap_a, snap_d;
    logic [7:0]      exp_data [4];
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};

    bus.req      = '0;
    bus.req_data = '0;
    model_en     = 1'b1;
    rst          = 1'b1;
    tick(3);

    check("rst_ack",   32'(bus.ack), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_err",   32'(bus.err), 0);
    check("rst_owner", 32'(bus.owner), 0);
    check("rst_busy",  32'(bus.arb_busy), 0);
    check("rst_rqst",  32'(bus.uart_tx_rqst), 0);
    check("rst_data",  32'(bus.uart_tx_data), 0);
    rst = 1'b0;
    tick(1);

    // Single request from requester 1
    bus.req_data = {8'h00, 8'h00, 8'hA5, 8'h00};
    bus.req      = 4'b0010;
    tick(1);
    check("t1_ack",   32'(bus.ack), 'b0010);
    check("t1_rqst",  32'(bus.uart_tx_rqst), 1);
    check("t1_data",  32'(bus.uart_tx_data), 'hA5);
    check("t1_owner", 32'(bus.owner), 1);
    check("t1_busy",  32'(bus.arb_busy), 1);
    bus.req      = '0;
    bus.req_data = '1;
    tick(1);
    check("t1_ack_pulse", 32'(bus.ack), 0);
    check("t1_rqst_hold", 32'(bus.uart_tx_rqst), 1);
    tick(1);
    check("t1_rqst_drop", 32'(bus.uart_tx_rqst), 0);
    check("t1_busy_mid",  32'(bus.arb_busy), 1);
    wait_vec(1, "t1_done", v, c);
    check("t1_done",      32'(v), 'b0010);
    check("t1_busy_end",  32'(bus.arb_busy), 0);
    check("t1_data_held", 32'(bus.uart_tx_data), 'hA5);
    tick(1);
    #1;
    check("t1_done_pulse", 32'(bus.done), 0);
    check("t1_done_once",  32'(done_cnt[1]), 1);
    check("t1_ack_once",   32'(ack_cnt[1]), 1);

    // All four requesting, held high
    do_reset();
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_vec(0, "t2_ack", v, c);
      check("t2_ack",   32'(v), 32'(1) << (k % 4));
      check("t2_owner", 32'(bus.owner), 32'(k % 4));
      check("t2_data",  32'(bus.uart_tx_data), 32'(exp_data[k % 4]));
      if (k == 4) bus.req = '0;
      wait_vec(1, "t2_done", v, c);
      check("t2_done", 32'(v), 32'(1) << (k % 4));
    end
    tick(2);
    check("t2_frames", 32'(m_frames), 5);

    // Back-to-back: requester 3 re-requests right after its done, 0 pending
    do_reset();
    bus.req_data = {8'hD3, 8'h00, 8'h00, 8'hC0};
    bus.req      = 4'b1000;
    wait_vec(0, "t3_ack3", v, c);
    check("t3_ack3", 32'(v), 'b1000);
    bus.req = '0;
    tick(2);
    bus.req = 4'b0001;
    wait_vec(1, "t3_done3", v, c);
    check("t3_done3", 32'(v), 'b1000);
    bus.req = 4'b1001;
    wait_vec(0, "t3_ack0", v, c);
    check("t3_order0", 32'(v), 'b0001);
    check("t3_data0",  32'(bus.uart_tx_data), 'hC0);
    bus.req = 4'b1000;
    wait_vec(1, "t3_done0", v, c);
    check("t3_done0", 32'(v), 'b0001);
    wait_vec(0, "t3_ack3b", v, c);
    check("t3_ack3b", 32'(v), 'b1000);
    bus.req = '0;
    wait_vec(1, "t3_done3b", v, c);
    check("t3_done3b", 32'(v), 'b1000);
    tick(2);
    check("t3_frames", 32'(m_frames), 3);

    // Asynchronous reset in WAIT_DONE
    do_reset();
    bus.req_data = {8'h04, 8'h03, 8'h02, 8'h01};
    bus.req      = 4'b0010;
    wait_vec(0, "t4_ack", v, c);
    check("t4_ack", 32'(v), 'b0010);
    bus.req = '0;
    tick(3);
    check("t4_wait_state", 32'(bus.uart_tx_rqst), 0);
    check("t4_wait_busy",  32'(bus.arb_busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_busy",  32'(bus.arb_busy), 0);
    check("t4_rst_owner", 32'(bus.owner), 0);
    check("t4_rst_data",  32'(bus.uart_tx_data), 0);
    check("t4_rst_done",  32'(bus.done), 0);
    snap_d = done_cnt[1];
    tick(2);
    rst = 1'b0;
    tick(20);
    #1;
    check("t4_no_done", 32'(done_cnt[1]), 32'(snap_d));
    bus.req = 4'b0101;
    wait_vec(0, "t4_ack0", v, c);
    check("t4_ptr0", 32'(v), 'b0001);
    bus.req = 4'b0100;
    wait_vec(1, "t4_done0", v, c);
    check("t4_done0", 32'(v), 'b0001);
    wait_vec(0, "t4_ack2", v, c);
    check("t4_ack2",  32'(v), 'b0100);
    check("t4_data2", 32'(bus.uart_tx_data), 'h03);
    bus.req = '0;
    wait_vec(1, "t4_done2", v, c);
    check("t4_done2", 32'(v), 'b0100);

    // UART that never goes busy
    do_reset();
    model_en = 1'b0;
    bus.req  = 4'b0011;
    wait_vec(0, "t5_ack0", v, c);
    check("t5_ack0", 32'(v), 'b0001);
`ifdef UART_ARB_TIMEOUT_EN
    bus.req = 4'b0010;
    wait_vec(2, "t5_err", v, c);
    check("t5_err",       32'(v), 'b0001);
    check("t5_err_cycle", 32'(c), TMO);
    check("t5_rqst",      32'(bus.uart_tx_rqst), 0);
    check("t5_busy",      32'(bus.arb_busy), 0);
    wait_vec(0, "t5_ack1", v, c);
    check("t5_ack1",     32'(v), 'b0010);
    check("t5_ack1_lat", 32'(c), 1);
    model_en = 1'b1;
    bus.req  = '0;
    wait_vec(1, "t5_done1", v, c);
    check("t5_done1", 32'(v), 'b0010);
`else
    bus.req = '0;
    tick(40);
    check("t5_rqst_wait", 32'(bus.uart_tx_rqst), 1);
    check("t5_busy_wait", 32'(bus.arb_busy), 1);
    check("t5_err_zero",  32'(bus.err), 0);
    model_en = 1'b1;
    wait_vec(1, "t5_done0", v, c);
    check("t5_done0", 32'(v), 'b0001);
`endif

    // Requester 1 pulses and withdraws while 0 owns the UART
    do_reset();
    #1;
    snap_a = ack_cnt[1];
    snap_d = done_cnt[1];
    bus.req = 4'b0001;
    wait_vec(0, "t6_ack0", v, c);
    check("t6_ack0", 32'(v), 'b0001);
    bus.req = '0;
    tick(3);
    bus.req = 4'b0010;
    tick(2);
    bus.req = '0;
    wait_vec(1, "t6_done0", v, c);
    check("t6_done0", 32'(v), 'b0001);
    tick(10);
    #1;
    check("t6_no_ack1",  32'(ack_cnt[1]), 32'(snap_a));
    check("t6_no_done1", 32'(done_cnt[1]), 32'(snap_d));
    check("t6_idle",     32'(bus.arb_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
